uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 122 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   arb_state_e    : arbiter FSM encoding (IDLE / SEND)
//   MAX_BURST_DEF  : default words per grant before forced release
//   IDLE_TO_DEF    : default idle cycles under grant before forced release
//   cnt_width()    : bits needed to hold a count from 0 up to maxval
package uart_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } arb_state_e;

  localparam int unsigned MAX_BURST_DEF = 16;
  localparam int unsigned IDLE_TO_DEF   = 16;

  function automatic int unsigned cnt_width(input int unsigned maxval);
    int unsigned w;
    w = $clog2(maxval + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector.
//   req_i : request vector
//   ptr_i : index of the last served requester; search starts at ptr_i+1
//   win_o : one-hot winner (all zero when no request)
//   idx_o : binary index of the winner
//   any_o : at least one request is present
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IW    = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] win_o,
  output logic [IW-1:0]    idx_o,
  output logic             any_o
);

  always_comb begin : pick
    int unsigned c;
    win_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    c     = 0;
    // Offsets 1..N_REQ visit every requester once, the current owner last.
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      c = (32'(ptr_i) + k) % N_REQ;
      if (!any_o && req_i[c]) begin
        any_o    = 1'b1;
        win_o[c] = 1'b1;
        idx_o    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates N_REQ message sources onto one UART transmit FIFO write port.
//   clk, reset : clock, asynchronous active-high reset
//   req        : per-requester word available
//   din        : per-requester data, requester i at [i*DBIT +: DBIT]
//   last       : per-requester final-word qualifier
//   ack        : one-hot accept pulse to the granted requester
//   grant      : one-hot registered grant (zero when idle)
//   tx_full    : UART transmit FIFO full
//   wr_uart    : UART FIFO write strobe
//   w_data     : UART FIFO write data
//   busy       : arbiter is in SEND
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int DBIT      = 8,
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int IDLE_TO   = IDLE_TO_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*DBIT-1:0] din,
  input  logic [N_REQ-1:0]      last,
  output logic [N_REQ-1:0]      ack,
  output logic [N_REQ-1:0]      grant,
  input  logic                  tx_full,
  output logic                  wr_uart,
  output logic [DBIT-1:0]       w_data,
  output logic                  busy
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned BW = cnt_width(MAX_BURST);
  localparam int unsigned TW = cnt_width(IDLE_TO);

  arb_state_e       state_q;
  logic [N_REQ-1:0] grant_q;
  logic [IW-1:0]    gidx_q;
  logic [IW-1:0]    ptr_q;
  logic [BW-1:0]    burst_q, burst_d;
  logic [TW-1:0]    idle_q, idle_d;

  logic [N_REQ-1:0] pick_win;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             req_g, last_g, idle_cyc, release_w;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .win_o (pick_win),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Granted requester's lines are selected by masking with the one-hot
  // grant, so no out-of-range index can arise for non-power-of-2 N_REQ.
  always_comb begin
    busy     = (state_q == ST_SEND);
    req_g    = |(req & grant_q);
    last_g   = |(last & grant_q);
    wr_uart  = busy & req_g & ~tx_full;
    ack      = grant_q & {N_REQ{wr_uart}};
    w_data   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (busy && grant_q[i]) w_data = w_data | din[i*DBIT +: DBIT];
    end
    grant    = grant_q;

    idle_cyc = busy & ~req_g & ~tx_full;
    burst_d  = burst_q + BW'(1);
    idle_d   = idle_q + TW'(1);
    // Coinciding causes collapse into one release by construction.
    release_w = (wr_uart  & (last_g | (burst_d == BW'(MAX_BURST)))) |
                (idle_cyc & (idle_d == TW'(IDLE_TO)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= IW'(N_REQ - 1);
      burst_q <= '0;
      idle_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            state_q <= ST_SEND;
            grant_q <= pick_win;
            gidx_q  <= pick_idx;
            burst_q <= '0;
            idle_q  <= '0;
          end
        end
        ST_SEND: begin
          if (wr_uart) begin
            burst_q <= burst_d;
            idle_q  <= '0;
          end else if (idle_cyc) begin
            idle_q  <= idle_d;
          end
          if (release_w) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= gidx_q;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] din;
  logic [3:0]  last;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic        tx_full;
  logic        wr_uart;
  logic [7:0]  w_data;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_arbiter #(
    .DBIT      (8),
    .N_REQ     (4),
    .MAX_BURST (16),
    .IDLE_TO   (16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .din     (din),
    .last    (last),
    .ack     (ack),
    .grant   (grant),
    .tx_full (tx_full),
    .wr_uart (wr_uart),
    .w_data  (w_data),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] din;
    logic [3:0]  last;
    logic        tx_full;
    logic [3:0]  e_grant;
    logic        e_wr;
    logic [7:0]  e_wdata;
    logic [3:0]  e_ack;
    logic        e_busy;
  } vec_t;

  vec_t vecs [0:14];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_idle_outs(input string nm);
    check({nm, " grant"},   32'(grant),   32'h0);
    check({nm, " busy"},    32'(busy),    32'h0);
    check({nm, " wr_uart"}, 32'(wr_uart), 32'h0);
    check({nm, " ack"},     32'(ack),     32'h0);
    check({nm, " w_data"},  32'(w_data),  32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req = '0; din = '0; last = '0; tx_full = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic apply_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      req = vecs[i].req; din = vecs[i].din; last = vecs[i].last; tx_full = vecs[i].tx_full;
      #1;
      check($sformatf("vec%0d grant", i),   32'(grant),   32'(vecs[i].e_grant));
      check($sformatf("vec%0d wr_uart", i), 32'(wr_uart), 32'(vecs[i].e_wr));
      check($sformatf("vec%0d w_data", i),  32'(w_data),  32'(vecs[i].e_wdata));
      check($sformatf("vec%0d ack", i),     32'(ack),     32'(vecs[i].e_ack));
      check($sformatf("vec%0d busy", i),    32'(busy),    32'(vecs[i].e_busy));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int writes;
    int held;
    bit granted;
    bit released;

    // Single requester 2: three words, last on the third (ptr=3 after reset)
    vecs[0]  = '{4'b0100, 32'h0041_0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
    vecs[1]  = '{4'b0100, 32'h0041_0000, 4'b0000, 1'b0, 4'b0100, 1'b1, 8'h41, 4'b0100, 1'b1};
    vecs[2]  = '{4'b0100, 32'h0042_0000, 4'b0000, 1'b0, 4'b0100, 1'b1, 8'h42, 4'b0100, 1'b1};
    vecs[3]  = '{4'b0100, 32'h0043_0000, 4'b0100, 1'b0, 4'b0100, 1'b1, 8'h43, 4'b0100, 1'b1};
    vecs[4]  = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
    // Round robin, all requesting one-word messages, from reset: 0,1,2,3,0
    vecs[5]  = '{4'b1111, 32'h5352_5150, 4'b1111, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
    vecs[6]  = '{4'b1111, 32'h5352_5150, 4'b1111, 1'b0, 4'b0001, 1'b1, 8'h50, 4'b0001, 1'b1};
    vecs[7]  = '{4'b1111, 32'h5352_5150, 4'b1111, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
    vecs[8]  = '{4'b1111, 32'h5352_5150, 4'b1111, 1'b0, 4'b0010, 1'b1, 8'h51, 4'b0010, 1'b1};
    vecs[9]  = '{4'b1111, 32'h5352_5150, 4'b1111, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
    vecs[10] = '{4'b1111, 32'h5352_5150, 4'b1111, 1'b0, 4'b0100, 1'b1, 8'h52, 4'b0100, 1'b1};
    vecs[11] = '{4'b1111, 32'h5352_5150, 4'b1111, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
    vecs[12] = '{4'b1111, 32'h5352_5150, 4'b1111, 1'b0, 4'b1000, 1'b1, 8'h53, 4'b1000, 1'b1};
    vecs[13] = '{4'b1111, 32'h5352_5150, 4'b1111, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
    vecs[14] = '{4'b1111, 32'h5352_5150, 4'b1111, 1'b0, 4'b0001, 1'b1, 8'h50, 4'b0001, 1'b1};

    // Outputs held at zero during reset even with all inputs active
    reset = 1'b1; req = 4'b1111; din = 32'hFFFF_FFFF; last = 4'b1111; tx_full = 1'b0;
    @(negedge clk); #1;
    check_idle_outs("in_reset");
    @(negedge clk);
    reset = 1'b0; req = '0; din = '0; last = '0;

    apply_vecs(0, 4);
    do_reset();
    apply_vecs(5, 14);

    // Backpressure mid-message, then a long stall with req low (no timeout)
    do_reset();
    @(negedge clk); req = 4'b0001; din = 32'h10; last = '0; tx_full = 1'b0; #1;
    check("bp idle grant", 32'(grant), 32'h0);
    @(negedge clk); #1;
    check("bp word0 wr", 32'(wr_uart), 32'h1);
    check("bp word0 data", 32'(w_data), 32'h10);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); din = 32'h11; tx_full = 1'b1; #1;
      check($sformatf("bp stall%0d wr", i),    32'(wr_uart), 32'h0);
      check($sformatf("bp stall%0d ack", i),   32'(ack),     32'h0);
      check($sformatf("bp stall%0d grant", i), 32'(grant),   32'h1);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); req = '0; tx_full = 1'b1; #1;
      check($sformatf("bp noreq%0d grant", i), 32'(grant), 32'h1);
    end
    @(negedge clk); req = 4'b0001; tx_full = 1'b0; din = 32'h11; last = 4'b0001; #1;
    check("bp resume wr", 32'(wr_uart), 32'h1);
    check("bp resume data", 32'(w_data), 32'h11);
    check("bp resume ack", 32'(ack), 32'h1);
    @(negedge clk); req = '0; last = '0; #1;
    check("bp done grant", 32'(grant), 32'h0);
    check("bp done busy", 32'(busy), 32'h0);

    // Burst limit: requester 1 streams without last, requester 3 waiting
    do_reset();
    writes = 0; granted = 0; released = 0;
    for (int cyc = 0; cyc < 40 && !released; cyc++) begin
      @(negedge clk);
      req = 4'b1010; last = '0; tx_full = 1'b0;
      din = {8'hEE, 8'h00, 8'(8'h60 + writes), 8'h00};
      #1;
      if (grant == 4'b0010) begin
        granted = 1;
        if (wr_uart) begin
          check($sformatf("burst w%0d data", writes), 32'(w_data), 32'(8'h60 + writes));
          writes++;
        end
      end else if (granted) begin
        released = 1;
      end
    end
    check("burst released", 32'(released), 32'h1);
    check("burst writes", 32'(writes), 32'd16);
    check("burst gap grant", 32'(grant), 32'h0);
    @(negedge clk); #1;
    check("burst next grant", 32'(grant), 32'b1000);
    check("burst next data", 32'(w_data), 32'hEE);

    // Idle timeout: one word, then req drops
    do_reset();
    @(negedge clk); req = 4'b0001; din = 32'h70; last = '0; tx_full = 1'b0; #1;
    @(negedge clk); #1;
    check("to word wr", 32'(wr_uart), 32'h1);
    check("to word data", 32'(w_data), 32'h70);
    held = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk); req = '0; #1;
      if (grant != 4'b0001) break;
      held++;
    end
    check("to held cycles", 32'(held), 32'd16);
    check("to released busy", 32'(busy), 32'h0);
    @(negedge clk); req = 4'b0001; #1;
    check("to rearb idle", 32'(grant), 32'h0);
    @(negedge clk); #1;
    check("to rearb grant", 32'(grant), 32'h1);
    check("to rearb wr", 32'(wr_uart), 32'h1);

    // Asynchronous reset mid-burst after five words
    do_reset();
    @(negedge clk); req = 4'b0001; din = 32'h80; last = '0; tx_full = 1'b0; #1;
    check("mr idle grant", 32'(grant), 32'h0);
    for (int w = 0; w < 5; w++) begin
      @(negedge clk); din = 32'(8'h80 + w); #1;
      check($sformatf("mr w%0d data", w), 32'(w_data), 32'(8'h80 + w));
    end
    @(negedge clk); din = 32'h85; #1;
    check("mr pre wr", 32'(wr_uart), 32'h1);
    #2 reset = 1'b1;
    #1;
    check_idle_outs("mr async");
    @(negedge clk); reset = 1'b0; req = 4'b1111; #1;
    check("mr post idle", 32'(grant), 32'h0);
    @(negedge clk); #1;
    check("mr post grant", 32'(grant), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
